// File: rtl/pipeline_stage_elastic.sv
// rtl/pipeline_stage_elastic.sv - elastic pipeline stage register with 2-entry skid buffer
module pipeline_stage_elastic #(
    parameter int unsigned       WIDTH  = 32,
    parameter logic [WIDTH-1:0]  BUBBLE = '0,
    parameter int unsigned       CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       occupancy,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             main_v, skid_v, acc, take;

    // main holds the older entry and drives the output; skid only fills when
    // the stage accepts while downstream is not taking
    assign main_v    = (state_q != ST_EMPTY);
    assign skid_v    = (state_q == ST_TWO);
    // ready depends only on local state so stalls never form a combinational ready chain
    assign in_ready  = ~skid_v & ~flush & ~reset;
    assign out_valid = main_v;
    assign out_data  = main_v ? main_q : BUBBLE;
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};
    assign stall_cnt = stall_q;
    assign acc       = in_valid & in_ready;
    assign take      = main_v & out_ready;

    // next-state and data steering; flush overrides every transition
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (acc) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (acc && take) begin
                        main_d = in_data;
                    end else if (acc) begin
                        state_d = ST_TWO;
                        skid_d  = in_data;
                    end else if (take) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (take) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // saturating count of cycles where a valid output is held back
    always_comb begin
        stall_d = stall_q;
        if (main_v && !out_ready && !flush && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + 1'b1;
        end
    end

    // state registers; reset drops every entry at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipeline_stage_elastic.sv
// tb/tb_pipeline_stage_elastic.sv - scoreboard bench for pipeline_stage_elastic
module tb_pipeline_stage_elastic;

    localparam logic [31:0] BUB  = 32'h01000000;
    localparam int unsigned CMAX = 65535;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [1:0]  occupancy;
    logic [15:0] stall_cnt;

    logic       s_flush, s_in_valid, s_in_ready, s_out_valid, s_out_ready;
    logic [7:0] s_in_data, s_out_data;
    logic [1:0] s_occ, s_stall;

    logic       w_flush, w_in_valid, w_in_ready, w_out_valid, w_out_ready;
    logic [0:0] w_in_data, w_out_data;
    logic [1:0] w_occ;
    logic [3:0] w_stall;

    int checks = 0;
    int errors = 0;

    logic [31:0] sb[$];
    int unsigned m_cnt = 0;
    bit          m_rdy, m_take;

    always #5 clk = ~clk;

    pipeline_stage_elastic #(.WIDTH(32), .BUBBLE(BUB), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipeline_stage_elastic #(.WIDTH(8), .BUBBLE(8'h00), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .flush(s_flush),
        .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data),
        .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data),
        .occupancy(s_occ), .stall_cnt(s_stall)
    );

    pipeline_stage_elastic #(.WIDTH(1), .BUBBLE(1'b0), .CNT_W(4)) dut_w1 (
        .clk(clk), .reset(reset), .flush(w_flush),
        .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
        .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
        .occupancy(w_occ), .stall_cnt(w_stall)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: a FIFO of at most two entries, updated on each edge
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sb.delete();
            m_cnt = 0;
        end else begin
            m_rdy  = (sb.size() < 2) && !flush;
            m_take = (sb.size() != 0) && out_ready;
            if ((sb.size() != 0) && !out_ready && !flush && (m_cnt < CMAX)) m_cnt++;
            if (flush) begin
                sb.delete();
            end else begin
                if (m_take) void'(sb.pop_front());
                if (m_rdy && in_valid) sb.push_back(in_data);
            end
        end
    end

    // monitor: compare every visible output against the model mid-cycle
    always @(negedge clk) begin
        check("mon_valid", {63'd0, out_valid}, {63'd0, sb.size() != 0});
        check("mon_data", {32'd0, out_data}, {32'd0, (sb.size() != 0) ? sb[0] : BUB});
        check("mon_occ", {62'd0, occupancy}, 64'(sb.size()));
        check("mon_ready", {63'd0, in_ready},
              {63'd0, (sb.size() < 2) && !flush && !reset});
        check("mon_stall", {48'd0, stall_cnt}, 64'(m_cnt));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 0; flush = 0; out_ready = 0; in_data = '0;
        s_flush = 0; s_in_valid = 0; s_out_ready = 0; s_in_data = '0;
        w_flush = 0; w_in_valid = 0; w_out_ready = 0; w_in_data = '0;
        reset = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    initial begin
        do_reset();
        check("bubble_data", {32'd0, out_data}, {32'd0, BUB});
        check("bubble_valid", {63'd0, out_valid}, 64'd0);

        // streaming
        out_ready = 1; in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            in_data = 32'd21 + 32'(i);
            step();
            check("stream_data", {32'd0, out_data}, 64'd21 + 64'(i));
            check("stream_occ", {62'd0, occupancy}, 64'd1);
        end
        in_valid = 0;
        step();
        check("stream_stall", {48'd0, stall_cnt}, 64'd0);

        // back-pressure
        do_reset();
        in_valid = 1; in_data = 32'd21;
        step();
        in_data = 32'd22;
        step();
        in_valid = 0;
        check("bp_occ", {62'd0, occupancy}, 64'd2);
        check("bp_ready", {63'd0, in_ready}, 64'd0);
        repeat (3) step();
        out_ready = 1;
        check("bp_first", {32'd0, out_data}, 64'd21);
        step();
        check("bp_second", {32'd0, out_data}, 64'd22);
        check("bp_stall", {48'd0, stall_cnt}, 64'd4);
        step();
        check("bp_drained", {63'd0, out_valid}, 64'd0);

        // flush while full
        do_reset();
        in_valid = 1; in_data = 32'd21;
        step();
        in_data = 32'd22;
        step();
        check("fl_pre_occ", {62'd0, occupancy}, 64'd2);
        in_data = 32'd23; flush = 1;
        step();
        flush = 0; in_valid = 0;
        check("fl_occ", {62'd0, occupancy}, 64'd0);
        check("fl_valid", {63'd0, out_valid}, 64'd0);
        check("fl_data", {32'd0, out_data}, {32'd0, BUB});
        check("fl_stall", {48'd0, stall_cnt}, 64'd1);
        step();
        check("fl_no23", {62'd0, occupancy}, 64'd0);

        // async reset
        do_reset();
        in_valid = 1; in_data = 32'd21;
        step();
        in_data = 32'd22;
        step();
        in_valid = 0;
        repeat (4) step();
        check("ar_pre_occ", {62'd0, occupancy}, 64'd2);
        check("ar_pre_stall", {48'd0, stall_cnt}, 64'd5);
        #2;
        reset = 1;
        #1;
        check("ar_valid", {63'd0, out_valid}, 64'd0);
        check("ar_occ", {62'd0, occupancy}, 64'd0);
        check("ar_stall", {48'd0, stall_cnt}, 64'd0);
        check("ar_ready", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        reset = 0; in_valid = 1; in_data = 32'd21; out_ready = 1;
        @(posedge clk);
        #1;
        in_valid = 0;
        check("ar_first", {32'd0, out_data}, 64'd21);
        check("ar_first_v", {63'd0, out_valid}, 64'd1);

        // saturation with CNT_W=2
        do_reset();
        s_in_valid = 1; s_in_data = 8'h5A;
        step();
        s_in_valid = 0;
        check("sat_0", {62'd0, s_stall}, 64'd0);
        for (int k = 1; k <= 6; k++) begin
            step();
            check("sat_k", {62'd0, s_stall}, (k < 3) ? 64'(k) : 64'd3);
        end
        check("sat_data", {56'd0, s_out_data}, 64'h5A);

        // WIDTH=1 pattern 1,0,1
        w_out_ready = 1; w_in_valid = 1; w_in_data = 1'b1;
        step();
        w_in_data = 1'b0;
        check("w1_a", {63'd0, w_out_data}, 64'd1);
        step();
        w_in_data = 1'b1;
        check("w1_b", {63'd0, w_out_data}, 64'd0);
        check("w1_bv", {63'd0, w_out_valid}, 64'd1);
        step();
        w_in_valid = 0;
        check("w1_c", {63'd0, w_out_data}, 64'd1);

        // randomized traffic on the main instance
        do_reset();
        for (int i = 0; i < 400; i++) begin
            step();
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 19) == 0);
        end
        step();
        in_valid = 0; flush = 0; out_ready = 1;
        repeat (4) step();
        check("final_empty", {62'd0, occupancy}, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_stage_elastic.md
Name: pipeline_stage_elastic

Overview:
Generic, parametrised stage register for the SPARC 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB). It replaces the fixed-width stage registers with a single module. The module adds a valid/ready handshake, a 2-entry skid buffer so that stalls do not create combinational ready paths, a synchronous flush that inserts a bubble, and a saturating stall counter. One instance sits between each pair of stages; field slicing is done outside the block.

Parameters:
WIDTH, 32, payload width in bits (PC plus control/instruction fields packed by the instantiating stage)
BUBBLE, 0 (WIDTH bits), value driven on out_data when the stage holds no valid entry (e.g. SPARC nop 32'h01000000 for an instruction lane)
CNT_W, 16, width of the stall counter

Ports:
clk  input  1  pipeline clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
flush  input  1  synchronous flush; discards all held and incoming data this cycle
in_valid  input  1  upstream stage presents in_data
in_ready  output  1  stage can accept in_data this cycle
in_data  input  WIDTH  upstream payload
out_valid  output  1  out_data is a valid entry
out_ready  input  1  downstream stage takes out_data this cycle
out_data  output  WIDTH  payload to downstream stage; BUBBLE when out_valid=0
occupancy  output  2  entries held: 0, 1 or 2
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Storage: main register (main_v, main_d) drives the output; skid register (skid_v, skid_d) holds overflow. FIFO order is always preserved: main is older than skid.
- States:
  - EMPTY: main_v=0, skid_v=0.
  - ONE: main_v=1, skid_v=0.
  - TWO: main_v=1, skid_v=1.
  - occupancy = main_v + skid_v.
- A transfer happens on a clock edge when valid and ready are both high. acc = in_valid & in_ready. take = out_valid & out_ready.
- in_ready = ~skid_v & ~flush & ~reset. It does not depend on out_ready.
- out_valid = main_v. out_data = main_v ? main_d : BUBBLE.
- Transitions (flush=0):
  - EMPTY: acc -> ONE, main_d<=in_data. Otherwise stay.
  - ONE: acc&take -> ONE, main_d<=in_data. acc&~take -> TWO, skid_d<=in_data. ~acc&take -> EMPTY. Neither -> stay, main_d held.
  - TWO: in_ready=0. take -> ONE, main_d<=skid_d, skid_v<=0. ~take -> stay, both held.
- Latency: an entry accepted at edge N is on out_data with out_valid=1 after edge N (visible in cycle N+1) if the stage was EMPTY or was draining. Sustained throughput is 1 entry per cycle with out_ready held high.
- flush=1 has priority over all transitions:
  - Next state is EMPTY and out_data returns to BUBBLE.
  - in_ready is forced 0, so no upstream transfer occurs.
  - A take in the same cycle still counts as completed for the downstream stage.
  - flush does not clear stall_cnt.
- stall_cnt:
  - Increments on each edge where out_valid=1, out_ready=0 and flush=0.
  - Holds at 2^CNT_W-1 (no wrap).
  - Cleared only by reset.
- reset (asynchronous, active-high):
  - Immediately clears main_v, skid_v and stall_cnt.
  - Outputs go to out_valid=0, out_data=BUBBLE, occupancy=0, stall_cnt=0, in_ready=0 (while reset is high).
  - main_d and skid_d are cleared to BUBBLE.
  - Reset asserted mid-transfer drops all entries with no partial update.
  - First accept is possible on the first edge after deassertion.
- Simultaneous events:
  - Accept in ONE while downstream takes: the stage stays ONE with no bubble.
  - In TWO, upstream must hold in_valid/in_data; the held data is not sampled until in_ready returns.
- Width rules: the payload is passed bit-exact; there is no truncation or extension. WIDTH=1 must be supported.

Test Plan:
- Streaming: out_ready=1, present 21,22,23,24 on consecutive cycles -> out_data 21,22,23,24 one cycle later each, occupancy never exceeds 1, stall_cnt=0.
- Back-pressure: in ONE holding 21, out_ready=0, present 22 -> occupancy=2 and in_ready=0 next cycle. Hold 3 cycles, then out_ready=1 -> out_data 21 then 22, stall_cnt=4 (includes the acceptance cycle), no loss or duplication.
- Flush: stage in TWO (21,22), assert flush with in_valid=1 and data 23 -> next cycle occupancy=0, out_valid=0, out_data=BUBBLE, 23 not accepted, stall_cnt unchanged.
- Async reset: with occupancy=2 and stall_cnt=5, raise reset between edges -> out_valid=0, occupancy=0, stall_cnt=0, in_ready=0 immediately without a clock. After deassert, present 21 -> out_data=21 one cycle later.
- Saturation: CNT_W=2, hold out_valid=1 with out_ready=0 for 6 cycles -> stall_cnt reads 1,2,3,3,3,3.
- Bubble value: BUBBLE=32'h01000000, stage empty -> out_data=32'h01000000 with out_valid=0. WIDTH=1 instance passes the pattern 1,0,1 unchanged.
